// File: rtl/skin_bbox_locator.sv
// ---------------------------------------------------------------------------
// skin_bbox_locator
//
// Takes the 1-bit skin mask from the YCbCr threshold stage and builds a
// bounding box of the skin pixels in each frame. A pixel counts only when it
// belongs to a horizontal run of at least MIN_RUN skin pixels. When the run
// reaches MIN_RUN, the whole run is counted at once and its left edge is
// back-dated. The box is published to the overlay/stitching logic on the
// vsync rising edge that closes the frame.
//
// Ports
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   pre_frame_vsync   frame sync (active high) from the skin stage
//   pre_frame_href    line valid from the skin stage
//   pre_frame_de      pixel valid from the skin stage
//   skin_bit          1 = skin pixel, sampled only when pre_frame_de = 1
//   box_x_min/x_max   left/right column of the last completed frame's box
//   box_y_min/y_max   top/bottom row of the last completed frame's box
//   box_pix_cnt       qualified pixel count of the last completed frame
//   box_valid         box_pix_cnt >= MIN_PIXELS
//   box_update        one-cycle pulse when the box_* outputs refresh
// ---------------------------------------------------------------------------
module skin_bbox_locator #(
   parameter int X_W        = 11,
   parameter int Y_W        = 11,
   parameter int CNT_W      = 22,
   parameter int MIN_RUN    = 8,     // 1..255
   parameter int MIN_PIXELS = 2048
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pre_frame_vsync,
   input  logic             pre_frame_href,
   input  logic             pre_frame_de,
   input  logic             skin_bit,
   output logic [X_W-1:0]   box_x_min,
   output logic [X_W-1:0]   box_x_max,
   output logic [Y_W-1:0]   box_y_min,
   output logic [Y_W-1:0]   box_y_max,
   output logic [CNT_W-1:0] box_pix_cnt,
   output logic             box_valid,
   output logic             box_update
);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACTIVE = 1'b1;

   localparam logic [X_W-1:0]   X_SAT    = {X_W{1'b1}};
   localparam logic [Y_W-1:0]   Y_SAT    = {Y_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
   localparam logic [7:0]       RUN_SAT  = 8'hFF;
   localparam logic [8:0]       RUN_THR  = 9'(MIN_RUN);
   localparam logic [X_W-1:0]   RUN_BACK = X_W'(MIN_RUN - 1);

   logic             state;
   logic             vsync_d, href_d;
   logic             frame_edge, line_end;
   logic [X_W-1:0]   x;
   logic [Y_W-1:0]   y;
   logic [7:0]       run;
   logic [8:0]       run_next;
   logic             line_has_de;

   logic [X_W-1:0]   acc_x_min, acc_x_max, acc_x_min_n, acc_x_max_n;
   logic [Y_W-1:0]   acc_y_min, acc_y_max, acc_y_min_n, acc_y_max_n;
   logic [CNT_W-1:0] acc_cnt, acc_cnt_n;
   logic [CNT_W:0]   cnt_sum;
   logic             pix, run_cross, run_extend;
   logic [X_W-1:0]   x_left;

   assign frame_edge = pre_frame_vsync & ~vsync_d;
   assign line_end   = ~pre_frame_href & href_d;

   // Pixel data is ignored until the first frame edge arms the block.
   assign pix        = pre_frame_de & skin_bit & (state == S_ACTIVE);
   assign run_next   = {1'b0, run} + 9'd1;
   assign run_cross  = pix && (run_next == RUN_THR);
   assign run_extend = pix && (run_next > RUN_THR);
   // Left edge of the run that has just reached MIN_RUN.
   assign x_left     = x - RUN_BACK;
   assign cnt_sum    = {1'b0, acc_cnt} + (run_cross ? (CNT_W+1)'(MIN_RUN) : (CNT_W+1)'(1));

   // Accumulator values including the current pixel. Both the normal update
   // and the publish use these, so a pixel on the frame edge is still counted
   // in the frame being closed.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves a latch.
      acc_x_min_n = acc_x_min;
      acc_x_max_n = acc_x_max;
      acc_y_min_n = acc_y_min;
      acc_y_max_n = acc_y_max;
      acc_cnt_n   = acc_cnt;
      if (run_cross || run_extend) begin
         if (x > acc_x_max) acc_x_max_n = x;
         if (y < acc_y_min) acc_y_min_n = y;
         if (y > acc_y_max) acc_y_max_n = y;
         acc_cnt_n = cnt_sum[CNT_W] ? CNT_SAT : cnt_sum[CNT_W-1:0];
      end
      if (run_cross && (x_left < acc_x_min)) acc_x_min_n = x_left;
   end

   // Sync edge registers and the pixel position/run counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d     <= 1'b0;
         href_d      <= 1'b0;
         x           <= '0;
         y           <= '0;
         run         <= '0;
         line_has_de <= 1'b0;
      end else begin
         // NOTE: state uses non-blocking assignments, so every branch reads pre-edge values.
         vsync_d <= pre_frame_vsync;
         href_d  <= pre_frame_href;

         if (frame_edge || line_end) begin
            x   <= '0;
            run <= '0;
         end else if (pre_frame_de) begin
            if (x != X_SAT) x <= x + 1'b1;
            if (!skin_bit)           run <= '0;
            else if (run != RUN_SAT) run <= run + 1'b1;
         end

         if (frame_edge) begin
            y <= '0;
         end else if (line_end && (line_has_de || pre_frame_de) && (y != Y_SAT)) begin
            y <= y + 1'b1;
         end

         if (frame_edge || line_end) line_has_de <= 1'b0;
         else if (pre_frame_de)      line_has_de <= 1'b1;
      end
   end

   // Frame FSM, accumulators and published outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         acc_x_min   <= '0;
         acc_x_max   <= '0;
         acc_y_min   <= '0;
         acc_y_max   <= '0;
         acc_cnt     <= '0;
         box_x_min   <= '0;
         box_x_max   <= '0;
         box_y_min   <= '0;
         box_y_max   <= '0;
         box_pix_cnt <= '0;
         box_valid   <= 1'b0;
         box_update  <= 1'b0;
      end else begin
         box_update <= 1'b0;
         if (frame_edge) begin
            state <= S_ACTIVE;
            if (state == S_ACTIVE) begin
               box_x_min   <= acc_x_min_n;
               box_x_max   <= acc_x_max_n;
               box_y_min   <= acc_y_min_n;
               box_y_max   <= acc_y_max_n;
               box_pix_cnt <= acc_cnt_n;
               box_valid   <= (acc_cnt_n >= CNT_W'(MIN_PIXELS));
               box_update  <= 1'b1;
            end
            acc_x_min <= X_SAT;
            acc_x_max <= '0;
            acc_y_min <= Y_SAT;
            acc_y_max <= '0;
            acc_cnt   <= '0;
         end else begin
            acc_x_min <= acc_x_min_n;
            acc_x_max <= acc_x_max_n;
            acc_y_min <= acc_y_min_n;
            acc_y_max <= acc_y_max_n;
            acc_cnt   <= acc_cnt_n;
         end
      end
   end

endmodule

// File: tb/tb_skin_bbox_locator.sv
// ---------------------------------------------------------------------------
// tb_skin_bbox_locator
//
// Directed bench for skin_bbox_locator (MIN_RUN = 8, MIN_PIXELS = 16).
// Frames are 120-pixel lines with 4 blanking cycles. A table of single-run
// frames is driven and the published box is compared against hand-computed
// values. Hand-written sequences cover the multi-cycle corner cases: a run
// broken by the line end, vsync on the last pixel of a run, and reset in the
// middle of a frame.
// ---------------------------------------------------------------------------
module tb_skin_bbox_locator;

   localparam int X_W    = 11;
   localparam int Y_W    = 11;
   localparam int CNT_W  = 22;
   localparam int LINE_W = 120;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             pre_frame_vsync, pre_frame_href, pre_frame_de, skin_bit;
   logic [X_W-1:0]   box_x_min, box_x_max;
   logic [Y_W-1:0]   box_y_min, box_y_max;
   logic [CNT_W-1:0] box_pix_cnt;
   logic             box_valid, box_update;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int x_min; int x_max; int y_min; int y_max; int cnt; int valid;
   } box_t;

   typedef struct {
      int   row_lo; int row_hi; int col_lo; int len;
      box_t exp;
   } vec_t;

   localparam int NVEC = 6;
   vec_t vecs [NVEC];
   box_t empty_box;

   skin_bbox_locator #(
      .X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W), .MIN_RUN(8), .MIN_PIXELS(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .pre_frame_vsync(pre_frame_vsync), .pre_frame_href(pre_frame_href),
      .pre_frame_de(pre_frame_de), .skin_bit(skin_bit),
      .box_x_min(box_x_min), .box_x_max(box_x_max),
      .box_y_min(box_y_min), .box_y_max(box_y_max),
      .box_pix_cnt(box_pix_cnt), .box_valid(box_valid), .box_update(box_update)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_box(input string tag, input box_t e);
      check({tag, " update"}, 32'(box_update), 1);
      check({tag, " x_min"},  32'(box_x_min),   e.x_min);
      check({tag, " x_max"},  32'(box_x_max),   e.x_max);
      check({tag, " y_min"},  32'(box_y_min),   e.y_min);
      check({tag, " y_max"},  32'(box_y_max),   e.y_max);
      check({tag, " cnt"},    32'(box_pix_cnt), e.cnt);
      check({tag, " valid"},  32'(box_valid),   e.valid);
   endtask

   // One line of LINE_W pixels with skin in [skin_lo, skin_lo+skin_len), then blanking.
   task automatic drive_line(input int skin_lo, input int skin_len);
      pre_frame_href = 1'b1;
      for (int c = 0; c < LINE_W; c++) begin
         pre_frame_de = 1'b1;
         skin_bit     = (c >= skin_lo) && (c < skin_lo + skin_len);
         tick();
      end
      pre_frame_href = 1'b0;
      pre_frame_de   = 1'b0;
      skin_bit       = 1'b0;
      repeat (4) tick();
   endtask

   // Vsync pulse. With expect_pub the closing frame's box is checked the cycle
   // after the rising edge, and the pulse must be gone the cycle after that.
   task automatic pulse_vsync(input string tag, input bit expect_pub, input box_t e);
      pre_frame_vsync = 1'b1;
      pre_frame_href  = 1'b0;
      pre_frame_de    = 1'b0;
      skin_bit        = 1'b0;
      tick();
      if (expect_pub) check_box(tag, e);
      else            check({tag, " no update"}, 32'(box_update), 0);
      tick();
      check({tag, " update drop"}, 32'(box_update), 0);
      pre_frame_vsync = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      empty_box = '{2047, 0, 2047, 0, 0, 0};
      vecs[0] = '{0, 3, 0, 0,    '{2047, 0, 2047, 0, 0, 0}};   // empty frame
      vecs[1] = '{10, 13, 100, 10, '{100, 109, 10, 13, 40, 1}};
      vecs[2] = '{5, 5, 50, 7,   '{2047, 0, 2047, 0, 0, 0}};   // run one short
      vecs[3] = '{2, 3, 0, 20,   '{0, 19, 2, 3, 40, 1}};       // run from column 0
      vecs[4] = '{0, 0, 112, 8,  '{112, 119, 0, 0, 8, 0}};     // exact run at line end
      vecs[5] = '{1, 2, 30, 8,   '{30, 37, 1, 2, 16, 1}};      // cnt == MIN_PIXELS

      rst_n = 1'b0;
      pre_frame_vsync = 1'b0;
      pre_frame_href  = 1'b0;
      pre_frame_de    = 1'b0;
      skin_bit        = 1'b0;
      repeat (3) tick();
      check("reset x_min", 32'(box_x_min), 0);
      check("reset cnt",   32'(box_pix_cnt), 0);
      check("reset update", 32'(box_update), 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // First vsync only arms the block.
      pulse_vsync("arm", 1'b0, empty_box);
      check("arm x_min held", 32'(box_x_min), 0);

      foreach (vecs[i]) begin
         for (int r = 0; r <= vecs[i].row_hi; r++) begin
            if (r >= vecs[i].row_lo) drive_line(vecs[i].col_lo, vecs[i].len);
            else                     drive_line(0, 0);
         end
         pulse_vsync($sformatf("vec%0d", i), 1'b1, vecs[i].exp);
      end

      // Run split across a line end: 4 px ending row 3, 4 px starting row 4.
      for (int r = 0; r <= 4; r++) begin
         if (r == 3)      drive_line(116, 4);
         else if (r == 4) drive_line(0, 4);
         else             drive_line(0, 0);
      end
      pulse_vsync("split", 1'b1, empty_box);

      // Vsync rising on the 8th skin pixel of a run in row 2.
      drive_line(0, 0);
      drive_line(0, 0);
      pre_frame_href = 1'b1;
      pre_frame_de   = 1'b1;
      skin_bit       = 1'b1;
      repeat (7) tick();
      pre_frame_vsync = 1'b1;
      tick();
      check_box("coinc", '{0, 7, 2, 2, 8, 0});
      pre_frame_href = 1'b0;
      pre_frame_de   = 1'b0;
      skin_bit       = 1'b0;
      tick();
      check("coinc update drop", 32'(box_update), 0);
      pre_frame_vsync = 1'b0;
      repeat (4) tick();
      drive_line(0, 0);
      pulse_vsync("after coinc", 1'b1, empty_box);

      // Reset after 20 qualified pixels (rows 10 and 11).
      for (int r = 0; r <= 11; r++) begin
         if (r >= 10) drive_line(100, 10);
         else         drive_line(0, 0);
      end
      rst_n = 1'b0;
      #1;
      check("midrst x_min", 32'(box_x_min), 0);
      check("midrst cnt",   32'(box_pix_cnt), 0);
      check("midrst valid", 32'(box_valid), 0);
      tick();
      rst_n = 1'b1;
      tick();
      pulse_vsync("rearm", 1'b0, empty_box);
      drive_line(0, 0);
      drive_line(30, 16);
      pulse_vsync("post rst", 1'b1, '{30, 45, 1, 1, 16, 1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
